// File: rtl/decode_issue_pkg.sv
// Shared types for the RV32I decode/issue stage: ALU opcodes, encoding fields
// and the registered issue bundle handed to execute.
package decode_issue_pkg;

    localparam int ISSUE_XLEN = 32;

    typedef enum logic [3:0] {
        ALU_NONE  = 4'd0,
        ALU_ADD   = 4'd1,
        ALU_SUB   = 4'd2,
        ALU_XOR   = 4'd3,
        ALU_OR    = 4'd4,
        ALU_AND   = 4'd5,
        ALU_SLL   = 4'd6,
        ALU_SRL   = 4'd7,
        ALU_SLA   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_SLT   = 4'd10,
        ALU_SLTU  = 4'd11,
        ALU_LUI   = 4'd12,
        ALU_AUIPC = 4'd13
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef struct packed {
        alu_op_e                 alu_op;
        logic [ISSUE_XLEN-1:0]   a;
        logic [ISSUE_XLEN-1:0]   b;
        logic [ISSUE_XLEN-1:0]   pc;
        logic [4:0]              rd;
        logic                    rd_we;
        logic                    illegal;
    } issue_t;

endpackage

// File: rtl/decode_issue_scoreboard.sv
// Busy-bit scoreboard for RAW hazard detection; x0 is never busy.
module decode_issue_scoreboard #(
    parameter int NREGS = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_en_i,
    input  logic [4:0] set_rd_i,
    input  logic       clr_en_i,
    input  logic [4:0] clr_rd_i,
    input  logic       fclr_en_i,
    input  logic [4:0] fclr_rd_i,
    input  logic [4:0] rd_a_addr_i,
    input  logic [4:0] rd_b_addr_i,
    output logic       rd_a_busy_o,
    output logic       rd_b_busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // A newly issued writer owns the bit even if an older result retires the same cycle.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NREGS; i++) begin
            if (set_en_i && (set_rd_i == i[4:0])) begin
                busy_d[i] = 1'b1;
            end else if ((clr_en_i && (clr_rd_i == i[4:0])) ||
                         (fclr_en_i && (fclr_rd_i == i[4:0]))) begin
                busy_d[i] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rd_a_busy_o = busy_q[rd_a_addr_i];
    assign rd_b_busy_o = busy_q[rd_b_addr_i];

endmodule

// File: rtl/decode_issue.sv
// RV32I integer decode/issue stage: decodes OP, OP-IMM, LUI, AUIPC, checks the
// scoreboard for RAW hazards and holds one issued instruction for the ALU.
module decode_issue
    import decode_issue_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_alu_op,
    output logic [XLEN-1:0] out_alu_a,
    output logic [XLEN-1:0] out_alu_b,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_illegal
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd_f;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] shamt;

    issue_t dec;
    logic   legal;
    logic   rs1_used;
    logic   rs2_used;
    logic   rs1_busy;
    logic   rs2_busy;
    logic   hazard;
    logic   in_fire;

    issue_t issue_q, issue_d;
    logic   valid_q, valid_d;

    assign opcode   = in_instr[6:0];
    assign rd_f     = in_instr[11:7];
    assign f3       = in_instr[14:12];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];
    assign f7       = in_instr[31:25];
    assign imm_i    = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_u    = {12'b0, in_instr[31:12]};
    assign shamt    = {27'b0, in_instr[24:20]};

    always_comb begin
        dec      = '0;
        dec.pc   = in_pc + 32'd4;
        dec.rd   = rd_f;
        legal    = 1'b1;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                dec.a    = rs1_data;
                dec.b    = rs2_data;
                legal    = (f7 == F7_BASE) ||
                           ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
                unique case (f3)
                    F3_ADD:  dec.alu_op = (f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                    F3_SLL:  dec.alu_op = ALU_SLL;
                    F3_SLT:  dec.alu_op = ALU_SLT;
                    F3_SLTU: dec.alu_op = ALU_SLTU;
                    F3_XOR:  dec.alu_op = ALU_XOR;
                    F3_SR:   dec.alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    F3_OR:   dec.alu_op = ALU_OR;
                    default: dec.alu_op = ALU_AND;
                endcase
            end
            OPC_OP_IMM: begin
                rs1_used = 1'b1;
                dec.a    = rs1_data;
                dec.b    = imm_i;
                unique case (f3)
                    F3_ADD:  dec.alu_op = ALU_ADD;
                    F3_SLT:  dec.alu_op = ALU_SLT;
                    F3_SLTU: dec.alu_op = ALU_SLTU;
                    F3_XOR:  dec.alu_op = ALU_XOR;
                    F3_OR:   dec.alu_op = ALU_OR;
                    F3_AND:  dec.alu_op = ALU_AND;
                    F3_SLL: begin
                        dec.alu_op = ALU_SLL;
                        dec.b      = shamt;
                        legal      = (f7 == F7_BASE);
                    end
                    default: begin
                        dec.alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        dec.b      = shamt;
                        legal      = (f7 == F7_BASE) || (f7 == F7_ALT);
                    end
                endcase
            end
            OPC_LUI: begin
                dec.alu_op = ALU_LUI;
                dec.b      = imm_u;
            end
            OPC_AUIPC: begin
                dec.alu_op = ALU_AUIPC;
                dec.b      = imm_u;
            end
            default: legal = 1'b0;
        endcase
        // Illegal encodings still issue with a clean payload so execute can trap.
        if (!legal) begin
            dec.alu_op  = ALU_NONE;
            dec.a       = '0;
            dec.b       = '0;
            dec.illegal = 1'b1;
        end
        dec.rd_we = legal && (rd_f != 5'd0);
    end

    decode_issue_scoreboard #(
        .NREGS(NREGS)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en_i   (in_fire && dec.rd_we),
        .set_rd_i   (dec.rd),
        .clr_en_i   (wb_valid),
        .clr_rd_i   (wb_rd),
        .fclr_en_i  (flush && valid_q && issue_q.rd_we),
        .fclr_rd_i  (issue_q.rd),
        .rd_a_addr_i(rs1_addr),
        .rd_b_addr_i(rs2_addr),
        .rd_a_busy_o(rs1_busy),
        .rd_b_busy_o(rs2_busy)
    );

    assign hazard   = (rs1_used && rs1_busy) || (rs2_used && rs2_busy);
    assign in_ready = !hazard && (!valid_q || out_ready) && !flush;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        issue_d = in_fire ? dec : issue_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (in_fire) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            issue_q <= '0;
        end else begin
            valid_q <= valid_d;
            issue_q <= issue_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_alu_op  = issue_q.alu_op;
    assign out_alu_a   = issue_q.a;
    assign out_alu_b   = issue_q.b;
    assign out_pc      = issue_q.pc;
    assign out_rd      = issue_q.rd;
    assign out_rd_we   = issue_q.rd_we;
    assign out_illegal = issue_q.illegal;

endmodule

// File: tb/tb_decode_issue.sv
// Directed testbench for decode_issue with hand-computed expected values.
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alu_op;
    logic [31:0] out_alu_a;
    logic [31:0] out_alu_b;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decode_issue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_alu_op (out_alu_op),
        .out_alu_a  (out_alu_a),
        .out_alu_b  (out_alu_b),
        .out_pc     (out_pc),
        .out_rd     (out_rd),
        .out_rd_we  (out_rd_we),
        .out_illegal(out_illegal)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
        rs1_data = 32'h0; rs2_data = 32'h0; wb_valid = 1'b0; wb_rd = 5'd0;
        flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h want 0", out_valid); end
        n_checks++; if ({out_alu_op, out_alu_a, out_alu_b, out_pc, out_rd, out_rd_we, out_illegal} !== '0) begin
            n_fail++; $display("FAIL reset_regs: op=%0h a=%0h b=%0h pc=%0h rd=%0h want all 0", out_alu_op, out_alu_a, out_alu_b, out_pc, out_rd);
        end
    endtask

    task automatic test_addi();
        in_instr = 32'h00500093; in_pc = 32'h100; rs1_data = 32'h0; in_valid = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL addi_in_ready: got %0h want 1", in_ready); end
        n_checks++; if (rs1_addr !== 5'd0 || rs2_addr !== 5'd5) begin n_fail++; $display("FAIL addi_rs_addr: got %0d/%0d want 0/5", rs1_addr, rs2_addr); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %0h want 1", out_valid); end
        n_checks++; if (out_alu_op !== 4'd1) begin n_fail++; $display("FAIL addi_op: got %0d want 1", out_alu_op); end
        n_checks++; if (out_alu_a !== 32'h0 || out_alu_b !== 32'h5) begin n_fail++; $display("FAIL addi_ab: got %0h/%0h want 0/5", out_alu_a, out_alu_b); end
        n_checks++; if (out_pc !== 32'h104) begin n_fail++; $display("FAIL addi_pc: got %0h want 104", out_pc); end
        n_checks++; if (out_rd !== 5'd1 || out_rd_we !== 1'b1 || out_illegal !== 1'b0) begin
            n_fail++; $display("FAIL addi_rd: got rd=%0d we=%0h ill=%0h want 1/1/0", out_rd, out_rd_we, out_illegal);
        end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %0h want 0", out_valid); end
    endtask

    task automatic test_sub_hazard();
        in_instr = 32'h402081B3; in_pc = 32'h108; rs1_data = 32'h10; rs2_data = 32'h3;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            wb_valid = (c == 4); wb_rd = 5'd1;
            #1;
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL sub_stall_c%0d: got in_ready=%0h want 0", c, in_ready); end
            tick();
        end
        wb_valid = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sub_release: got in_ready=%0h want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_alu_op !== 4'd2) begin n_fail++; $display("FAIL sub_issue: got v=%0h op=%0d want 1/2", out_valid, out_alu_op); end
        n_checks++; if (out_alu_a !== 32'h10 || out_alu_b !== 32'h3 || out_rd !== 5'd3) begin
            n_fail++; $display("FAIL sub_payload: got a=%0h b=%0h rd=%0d want 10/3/3", out_alu_a, out_alu_b, out_rd);
        end
        tick();
    endtask

    task automatic test_lui_auipc();
        out_ready = 1'b1; in_valid = 1'b1;
        in_instr = 32'hABCDE2B7; in_pc = 32'h180; rs1_data = 32'hFFFF_FFFF;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lui_in_ready: got %0h want 1", in_ready); end
        tick();
        in_instr = 32'h00001317; in_pc = 32'h200;
        n_checks++; if (out_alu_op !== 4'd12 || out_alu_a !== 32'h0 || out_alu_b !== 32'h000ABCDE || out_rd !== 5'd5) begin
            n_fail++; $display("FAIL lui: got op=%0d a=%0h b=%0h rd=%0d want 12/0/abcde/5", out_alu_op, out_alu_a, out_alu_b, out_rd);
        end
        #1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_alu_op !== 4'd13 || out_pc !== 32'h204 || out_alu_b !== 32'h1 || out_alu_a !== 32'h0) begin
            n_fail++; $display("FAIL auipc: got v=%0h op=%0d pc=%0h b=%0h a=%0h want 1/13/204/1/0", out_valid, out_alu_op, out_pc, out_alu_b, out_alu_a);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h00000433; rs1_data = 32'h11; rs2_data = 32'h22; in_pc = 32'h300;
        #1;
        tick();
        in_instr = 32'h000004B3; rs1_data = 32'h33; rs2_data = 32'h44; in_pc = 32'h304;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_%0d: got %0h want 0", c, in_ready); end
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_alu_a !== 32'h11 || out_alu_b !== 32'h22 || out_rd !== 5'd8) begin
                n_fail++; $display("FAIL bp_stable_%0d: got v=%0h a=%0h b=%0h rd=%0d want 1/11/22/8", c, out_valid, out_alu_a, out_alu_b, out_rd);
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %0h want 1", in_ready); end
        tick();
        in_instr = 32'h00000533; rs1_data = 32'h55; rs2_data = 32'h66; in_pc = 32'h308;
        n_checks++; if (out_valid !== 1'b1 || out_alu_a !== 32'h33 || out_rd !== 5'd9) begin
            n_fail++; $display("FAIL b2b_first: got v=%0h a=%0h rd=%0d want 1/33/9", out_valid, out_alu_a, out_rd);
        end
        #1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_alu_a !== 32'h55 || out_pc !== 32'h30C || out_rd !== 5'd10) begin
            n_fail++; $display("FAIL b2b_second: got v=%0h a=%0h pc=%0h rd=%0d want 1/55/30c/10", out_valid, out_alu_a, out_pc, out_rd);
        end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %0h want 0", out_valid); end
    endtask

    task automatic test_srai();
        out_ready = 1'b1; in_valid = 1'b1;
        in_instr = 32'h40325213; rs1_data = 32'h80; in_pc = 32'h400;
        #1;
        tick();
        in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd4;
        n_checks++; if (out_alu_op !== 4'd9 || out_alu_b !== 32'h3 || out_alu_a !== 32'h80 || out_rd_we !== 1'b1 || out_illegal !== 1'b0) begin
            n_fail++; $display("FAIL srai: got op=%0d b=%0h a=%0h we=%0h ill=%0h want 9/3/80/1/0", out_alu_op, out_alu_b, out_alu_a, out_rd_we, out_illegal);
        end
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL srai_busy4: got in_ready=%0h want 0", in_ready); end
        tick();
        wb_valid = 1'b0;
        in_instr = 32'h80325213; in_valid = 1'b1;
        #1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_alu_op !== 4'd0 || out_rd_we !== 1'b0) begin
            n_fail++; $display("FAIL illegal: got v=%0h ill=%0h op=%0d we=%0h want 1/1/0/0", out_valid, out_illegal, out_alu_op, out_rd_we);
        end
        n_checks++; if (out_alu_a !== 32'h0 || out_alu_b !== 32'h0) begin n_fail++; $display("FAIL illegal_ab: got %0h/%0h want 0/0", out_alu_a, out_alu_b); end
        tick();
        in_instr = 32'h00020593;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_busy4: got in_ready=%0h want 1", in_ready); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h00100393; rs1_data = 32'h0; in_pc = 32'h500;
        #1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_rd !== 5'd7) begin n_fail++; $display("FAIL flush_held: got v=%0h rd=%0d want 1/7", out_valid, out_rd); end
        in_instr = 32'h00038613; flush = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %0h want 0", in_ready); end
        tick();
        flush = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0h want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_busy7: got in_ready=%0h want 1", in_ready); end
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h00100693; in_pc = 32'h600; rs1_data = 32'h0;
        #1;
        tick();
        in_instr = 32'h00068713;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got in_ready=%0h want 0", in_ready); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %0h want 0", out_valid); end
        n_checks++; if ({out_alu_op, out_alu_a, out_alu_b, out_pc, out_rd, out_rd_we, out_illegal} !== '0) begin
            n_fail++; $display("FAIL rst_mid_regs: op=%0h a=%0h pc=%0h rd=%0h want all 0", out_alu_op, out_alu_a, out_pc, out_rd);
        end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy: got in_ready=%0h want 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sub_hazard();
        test_lui_auipc();
        test_back_to_back();
        test_srai();
        test_flush();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
